// File: rtl/sha256_hashing_functions.sv
// Shared SHA-256 constants and types used by the message front end.
package sha256_hashing_functions;

   localparam int BLK_W  = 512;
   localparam int WORD_W = 32;
   localparam int ID_W   = 6;
   localparam int NWORDS = BLK_W / WORD_W;
   localparam int LEN_W  = 64;

   localparam logic [7:0] PAD_MARKER = 8'h80;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_SEND = 1'b1
   } msg_state_t;

   // Word holding only the padding marker in byte 0.
   function automatic logic [WORD_W-1:0] marker_word();
      return {PAD_MARKER, {(WORD_W-8){1'b0}}};
   endfunction

endpackage

// File: rtl/sha256_message_build_if.sv
// Word-in / block-out handshake bundle of the SHA-256 message builder.
interface sha256_message_build_if;
   import sha256_hashing_functions::*;

   logic [WORD_W-1:0] data_in;
   logic [ID_W-1:0]   data_in_id;
   logic [2:0]        data_in_bytes;
   logic              data_in_last;
   logic              data_in_valid;
   logic              data_in_ready;
   logic [BLK_W-1:0]  data_out;
   logic [ID_W-1:0]   data_out_id;
   logic              data_out_last;
   logic              data_out_valid;
   logic              data_out_ready;

   // Word source / block sink side.
   modport master (
      output data_in, data_in_id, data_in_bytes, data_in_last, data_in_valid,
      output data_out_ready,
      input  data_in_ready, data_out, data_out_id, data_out_last, data_out_valid
   );

   // The message builder itself.
   modport slave (
      input  data_in, data_in_id, data_in_bytes, data_in_last, data_in_valid,
      input  data_out_ready,
      output data_in_ready, data_out, data_out_id, data_out_last, data_out_valid
   );

endinterface

// File: rtl/sha256_pad_word.sv
// Keeps the first n bytes of a big-endian word, zeroes the rest and
// drops the 0x80 marker into byte n when n < 4.
module sha256_pad_word
   import sha256_hashing_functions::*;
(
   input  logic [WORD_W-1:0] word_in,
   input  logic [2:0]        nbytes,
   output logic [WORD_W-1:0] word_out
);

   logic [3:0] keep;

   // Byte mask (bit 3 = byte 0) and marker insertion.
   always_comb begin
      keep = 4'b1111;
      case (nbytes)
         3'd0:    keep = 4'b0000;
         3'd1:    keep = 4'b1000;
         3'd2:    keep = 4'b1100;
         3'd3:    keep = 4'b1110;
         default: keep = 4'b1111;
      endcase
      word_out = word_in & {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
      case (nbytes)
         3'd0:    word_out[31:24] = PAD_MARKER;
         3'd1:    word_out[23:16] = PAD_MARKER;
         3'd2:    word_out[15:8]  = PAD_MARKER;
         3'd3:    word_out[7:0]   = PAD_MARKER;
         default: ;
      endcase
   end

endmodule

// File: rtl/sha256_message_build.sv
// SHA-256 message builder: packs a big-endian word stream into 512-bit
// blocks with FIPS 180-4 padding and hands them to the compressor.
module sha256_message_build
   import sha256_hashing_functions::*;
(
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 en,
   input  logic                 sync_rst,
   sha256_message_build_if.slave bus
);

   msg_state_t                     state_q, state_d;
   logic [3:0]                     widx_q, widx_d;
   logic [60:0]                    bytecnt_q, bytecnt_d;
   logic                           xtra_pend_q, xtra_pend_d;
   logic                           xtra_80_q, xtra_80_d;
   logic                           first_q, first_d;
   logic                           rdy_q, rdy_d;
   logic                           last_q, last_d;
   logic [ID_W-1:0]                id_q, id_d;
   logic [NWORDS-1:0][WORD_W-1:0]  blk_q, blk_d;

   logic [2:0]        nbytes;
   logic [WORD_W-1:0] padded;
   logic              word_hs;
   logic              blk_hs;
   logic [3:0]        slot_w;
   logic [3:0]        slot_w1;
   logic [60:0]       bytecnt_inc;
   logic [LEN_W-1:0]  len_new;
   logic [LEN_W-1:0]  len_old;

   // Non-last words always carry four bytes; out-of-range counts clamp to 4.
   assign nbytes = (bus.data_in_last && (bus.data_in_bytes < 3'd4)) ? bus.data_in_bytes : 3'd4;

   sha256_pad_word u_pad (
      .word_in  (bus.data_in),
      .nbytes   (nbytes),
      .word_out (padded)
   );

   // Slot 0 sits in the top word of the packed block, so slots index downward.
   assign slot_w      = 4'd15 - widx_q;
   assign slot_w1     = 4'd14 - widx_q;
   assign bytecnt_inc = bytecnt_q + {58'd0, nbytes};
   assign len_new     = {bytecnt_inc, 3'b000};
   assign len_old     = {bytecnt_q, 3'b000};

   assign word_hs = (state_q == ST_FILL) && rdy_q && bus.data_in_valid;
   assign blk_hs  = (state_q == ST_SEND) && bus.data_out_ready;

   assign bus.data_in_ready  = rdy_q;
   assign bus.data_out       = blk_q;
   assign bus.data_out_id    = id_q;
   assign bus.data_out_last  = last_q;
   assign bus.data_out_valid = (state_q == ST_SEND);

   // Next-state: word packing and padding in FILL, block release in SEND.
   always_comb begin
      state_d     = state_q;
      widx_d      = widx_q;
      bytecnt_d   = bytecnt_q;
      xtra_pend_d = xtra_pend_q;
      xtra_80_d   = xtra_80_q;
      first_d     = first_q;
      last_d      = last_q;
      id_d        = id_q;
      blk_d       = blk_q;

      if (word_hs) begin
         blk_d[slot_w] = padded;
         bytecnt_d     = bytecnt_inc;
         if (first_q) begin
            id_d    = bus.data_in_id;
            first_d = 1'b0;
         end
         if (!bus.data_in_last) begin
            if (widx_q == 4'd15) begin
               state_d = ST_SEND;
               last_d  = 1'b0;
            end else begin
               widx_d = widx_q + 4'd1;
            end
         end else begin
            state_d = ST_SEND;
            first_d = 1'b1;
            last_d  = 1'b0;
            if (nbytes != 3'd4) begin
               // Marker already placed inside the last word.
               if (widx_q <= 4'd13) begin
                  blk_d[1] = len_new[63:32];
                  blk_d[0] = len_new[31:0];
                  last_d   = 1'b1;
               end else begin
                  xtra_pend_d = 1'b1;
                  xtra_80_d   = 1'b0;
               end
            end else begin
               // Full last word: marker goes into the following slot if one exists.
               if (widx_q != 4'd15) begin
                  blk_d[slot_w1] = marker_word();
               end
               if (widx_q <= 4'd12) begin
                  blk_d[1] = len_new[63:32];
                  blk_d[0] = len_new[31:0];
                  last_d   = 1'b1;
               end else begin
                  xtra_pend_d = 1'b1;
                  xtra_80_d   = (widx_q == 4'd15);
               end
            end
         end
      end

      if (blk_hs) begin
         blk_d = '0;
         if (xtra_pend_q) begin
            // Length-only block, loaded on the same edge the previous block leaves.
            if (xtra_80_q) begin
               blk_d[15] = marker_word();
            end
            blk_d[1]    = len_old[63:32];
            blk_d[0]    = len_old[31:0];
            last_d      = 1'b1;
            xtra_pend_d = 1'b0;
         end else begin
            if (last_q) begin
               bytecnt_d = '0;
            end
            widx_d  = '0;
            last_d  = 1'b0;
            state_d = ST_FILL;
         end
      end

      rdy_d = (state_d == ST_FILL);

      if (sync_rst) begin
         state_d     = ST_FILL;
         widx_d      = '0;
         bytecnt_d   = '0;
         xtra_pend_d = 1'b0;
         xtra_80_d   = 1'b0;
         first_d     = 1'b1;
         rdy_d       = 1'b0;
         last_d      = 1'b0;
         id_d        = '0;
         blk_d       = '0;
      end
   end

   // State register; en low freezes everything, sync_rst still takes effect.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= ST_FILL;
         widx_q      <= '0;
         bytecnt_q   <= '0;
         xtra_pend_q <= 1'b0;
         xtra_80_q   <= 1'b0;
         first_q     <= 1'b1;
         rdy_q       <= 1'b0;
         last_q      <= 1'b0;
         id_q        <= '0;
         blk_q       <= '0;
      end else if (en || sync_rst) begin
         state_q     <= state_d;
         widx_q      <= widx_d;
         bytecnt_q   <= bytecnt_d;
         xtra_pend_q <= xtra_pend_d;
         xtra_80_q   <= xtra_80_d;
         first_q     <= first_d;
         rdy_q       <= rdy_d;
         last_q      <= last_d;
         id_q        <= id_d;
         blk_q       <= blk_d;
      end
   end

endmodule

// File: doc/sha256_message_build.md
# sha256_message_build

Front end of the SHA-256 datapath that feeds `sha256_hash_compression`.
- Accepts a message as a stream of big-endian 32-bit words.
- Applies FIPS 180-4 padding: 0x80 marker, zero fill, 64-bit bit length.
- Emits 512-bit blocks with the message ID and a last-block flag on the compressor's block input handshake.
- Sits between the bus/DMA word interface and the compression core.

## Interface
Parameters:
- none. Widths are fixed by SHA-256 and come from the shared package.

Ports (reset `nrst`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `nrst`  in  1  asynchronous active-low reset
- `en`  in  1  global enable; low freezes all registers
- `sync_rst`  in  1  synchronous reset, same effect as `nrst`
- `data_in`  in  32  message word; byte 0 is [31:24]
- `data_in_id`  in  6  message ID, sampled on the first word of a message
- `data_in_bytes`  in  3  valid bytes in a last word (0..4); ignored and treated as 4 on non-last words
- `data_in_last`  in  1  final word of the message
- `data_in_valid`  in  1  word valid
- `data_in_ready`  out  1  block accepts a word (registered)
- `data_out`  out  512  block; word 0 is [511:480]
- `data_out_id`  out  6  message ID
- `data_out_last`  out  1  final block of the message
- `data_out_valid`  out  1  block valid
- `data_out_ready`  in  1  compressor accepts the block

## Operation
States: `FILL`, `SEND`.

Registers:
- `widx` (4b): next word slot.
- `bytecnt` (61b): message length in bytes.
- `xtra_pend`, `xtra_80`: extra padding block pending, and whether it starts with the 0x80 marker.
- `first`: next accepted word starts a new message.

`FILL`, on a word handshake:
- Write the word into slot `widx`.
- If `first`, latch `data_in_id` and clear `first`.
- Non-last word: `bytecnt += 4`. When `widx == 15`, go to `SEND` with last=0; otherwise `widx++`.
- Last word with n bytes:
  - Keep bytes 0..n-1 of the word and zero the rest.
  - `bytecnt += n`; final bit length L = {`bytecnt`, 3'b000}, taken mod 2^64.
- Placement of the last word at slot w:
  - n<4: byte n of slot w = 0x80.
    - w ≤ 13: slots 14/15 = L[63:32]/L[31:0]; last=1.
    - w ≥ 14: last=0; `xtra_pend`=1, `xtra_80`=0.
  - n=4, w ≤ 12: slot w+1 = 0x80000000; L in slots 14/15; last=1.
  - n=4, w = 13 or 14: slot w+1 = 0x80000000; last=0; `xtra_pend`=1, `xtra_80`=0.
  - n=4, w = 15: last=0; `xtra_pend`=1, `xtra_80`=1.
- After any last word: go to `SEND`, set `first`.

`SEND`, on a block handshake:
- `xtra_pend`=1: in the same edge, load the block:
  - slot 0 = 0x80000000 if `xtra_80`, else 0;
  - slots 1..13 = 0;
  - slots 14/15 = L;
  - last=1.
  - Clear `xtra_pend` and stay in `SEND`.
- Otherwise: clear the buffer, `widx`=0, go to `FILL`.
- At message end (the last block has handshaked): clear `bytecnt`.

General rules:
- Unwritten slots are always zero.
- Empty message: a last word with n=0 at w=0 gives a single block 0x80000000, 0…0, length 0.

## Timing
- Reset (`nrst` or `sync_rst`) drives:
  - state `FILL`, `widx`=0, `bytecnt`=0, `first`=1, `xtra_*`=0;
  - `data_in_ready`=0;
  - `data_out`=0, `data_out_id`=0, `data_out_last`=0, `data_out_valid`=0.
- `data_in_ready` rises the first enabled cycle after reset.
- `data_in_ready` equals the registered `state==FILL`. It falls the cycle after the word that completes a block.
- The word handshake at edge t gives `data_out_valid`=1 from t+1.
- The block handshake at edge u:
  - extra block pending: `data_out_valid` stays 1 with the new block at u+1;
  - otherwise: `data_out_valid`=0 and `data_in_ready`=1 at u+1.
- While `data_out_valid` is high and `data_out_ready` is low, `data_out`, `data_out_id` and `data_out_last` hold stable.
- `en`=0: all state holds; `data_in_ready` and `data_out_valid` are held at their registered values, and no handshake is taken.
- Reset mid-message discards the partial block and `bytecnt`. The next word is treated as a first word.
- Throughput: 16 word cycles + 1 handshake cycle per block.

## Structure
- Add to the shared `sha256_hashing_functions` package:
  - block width 512, word width 32, ID width 6;
  - pad marker 8'h80;
  - the `FILL`/`SEND` state enum typedef.
- Sub-module `sha256_pad_word` (combinational): given word and n, return the masked word with 0x80 inserted at byte n (n<4).

## Test plan
- "abc": one last word 0x61626300, n=3, id=5 -> one block: slot0=0x61626380, slots1-14=0, slot15=0x00000018, last=1, id=5. Via the compressor the digest is ba7816bf…f20015ad.
- Empty message: last word, n=0, id=1 -> slot0=0x80000000, rest 0, last=1, id=1.
- 56-byte message (last at w=13, n=4):
  - block 1: slots0-13 data, slot14=0x80000000, slot15=0, last=0;
  - block 2: zeros except slot15=0x000001C0, last=1.
- 64-byte message:
  - block 1: data, last=0;
  - block 2: slot0=0x80000000, slot15=0x00000200, last=1;
  - both blocks carry the same id.
- Backpressure: `data_out_ready` low for 10 cycles -> `data_out` stable and `data_in_ready`=0 throughout; the block is delivered exactly once.
- Reset after 7 words, then "abc" -> all outputs 0 during reset; the following block is identical to the first scenario.
